cache_ctrl_nway: RTL

Parametrised N-way set-associative write-back cache controller FSM, the successor to the 2-way controller. It sits between the CPU memory port and the cache datapath (tag/data/valid/dirty arrays, replacement unit) and drives the main-memory request/acknowledge handshake. New relative to the 2-way controller:
- configurable associativity;
- invalid-way-first allocation;
- registered victim selection;
- memory-handshake timeout with error reporting;
- full-cache flush sequencer.

---
 rtl/cache_pkg.sv | 36 +++
 rtl/cache_ctrl_nway_if.sv | 70 +++++++
 rtl/cache_flush_cnt.sv | 41 ++++
 rtl/cache_ctrl_nway.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the N-way write-back cache controller.
//   cache_state_t  - controller FSM state encoding, also exported as a debug output
//   first_invalid  - lowest-index invalid way of a set (ways above WAYS padded valid)
//   DEF_*          - default parameter values for the controller and its interface
package cache_pkg;

  localparam int DEF_WAYS    = 4;
  localparam int DEF_SETS    = 64;
  localparam int DEF_TIMEOUT = 255;

  // Widest supported associativity; helpers work on vectors of this width.
  localparam int MAX_WAYS  = 8;
  localparam int MAX_WAY_W = 3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK      = 3'd1,
    WB_REQ     = 3'd2,
    FILL_REQ   = 3'd3,
    FLUSH_SCAN = 3'd4,
    FLUSH_WB   = 3'd5,
    ERROR      = 3'd6
  } cache_state_t;

  // Lowest-index way whose valid bit is 0. The caller pads unused upper
  // ways with 1 so they are never chosen; result is 0 if every way is valid.
  function automatic logic [MAX_WAY_W-1:0] first_invalid(input logic [MAX_WAYS-1:0] valid_vec);
    logic [MAX_WAY_W-1:0] w;
    w = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (!valid_vec[i]) w = MAX_WAY_W'(i);
    end
    return w;
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_if.sv
// cache_ctrl_nway_if: bundle between the cache controller (master) and the
// CPU port / cache datapath / main-memory side (slave).
//   CPU:      cpu_read, cpu_write, flush_req in; cpu_ready out
//   Datapath: hit, hit_way, valid_vec, dirty_vec, lru_way in;
//             lru_update, lru_touch_way, byte_we, line_we, tag_we, data_in_sel,
//             wb_way, valid_we, dirty_we, valid_d, dirty_d,
//             flush_active, flush_idx out
//   Memory:   mem_ack in; mem_read, mem_write out
//   Status:   flush_done, error out; state_dbg exposes the FSM state
//
// Handshakes: cpu_read/cpu_write are request levels held by the CPU until the
// one-cycle cpu_ready pulse; mem_read/mem_write are request levels held by the
// controller until the one-cycle mem_ack pulse (accepted in any cycle of the
// request, including the first); flush_req is held until flush_active is seen.
interface cache_ctrl_nway_if #(
  parameter int WAYS = cache_pkg::DEF_WAYS,
  parameter int SETS = cache_pkg::DEF_SETS
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(SETS);

  logic             cpu_read;
  logic             cpu_write;
  logic             flush_req;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAYS-1:0]  valid_vec;
  logic [WAYS-1:0]  dirty_vec;
  logic [WAY_W-1:0] lru_way;
  logic             mem_ack;

  logic             cpu_ready;
  logic             lru_update;
  logic [WAY_W-1:0] lru_touch_way;
  logic [WAYS-1:0]  byte_we;
  logic [WAYS-1:0]  line_we;
  logic [WAYS-1:0]  tag_we;
  logic             data_in_sel;
  logic             mem_read;
  logic             mem_write;
  logic [WAY_W-1:0] wb_way;
  logic [WAYS-1:0]  valid_we;
  logic [WAYS-1:0]  dirty_we;
  logic             valid_d;
  logic             dirty_d;
  logic             flush_active;
  logic [IDX_W-1:0] flush_idx;
  logic             flush_done;
  logic             error;
  cache_pkg::cache_state_t state_dbg;

  modport master (
    input  cpu_read, cpu_write, flush_req, hit, hit_way, valid_vec, dirty_vec,
           lru_way, mem_ack,
    output cpu_ready, lru_update, lru_touch_way, byte_we, line_we, tag_we,
           data_in_sel, mem_read, mem_write, wb_way, valid_we, dirty_we,
           valid_d, dirty_d, flush_active, flush_idx, flush_done, error,
           state_dbg
  );

  modport slave (
    output cpu_read, cpu_write, flush_req, hit, hit_way, valid_vec, dirty_vec,
           lru_way, mem_ack,
    input  cpu_ready, lru_update, lru_touch_way, byte_we, line_we, tag_we,
           data_in_sel, mem_read, mem_write, wb_way, valid_we, dirty_we,
           valid_d, dirty_d, flush_active, flush_idx, flush_done, error,
           state_dbg
  );

endinterface

// File: rtl/cache_flush_cnt.sv
// cache_flush_cnt: {set index, way} walk counter for the flush sequencer.
//   clk, rst_n - clock, async active-low reset
//   clr        - synchronous clear to (0,0)
//   adv        - step to the next way, wrapping into the next set
//   idx, way   - current position
//   last       - position is (SETS-1, WAYS-1)
module cache_flush_cnt #(
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int WAY_W = $clog2(WAYS),
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [IDX_W-1:0] idx,
  output logic [WAY_W-1:0] way,
  output logic             last
);

  localparam int CW = IDX_W + WAY_W;

  // WAYS and SETS are powers of two, so one binary counter over {idx,way}
  // gives the way wrap and set increment for free.
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign {idx, way} = cnt;
  assign last       = &cnt;

endmodule

// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: N-way set-associative write-back cache controller FSM.
//   clk, rst_n - clock, async active-low reset
//   bus        - cache_ctrl_nway_if master: CPU request/ready, datapath
//                array strobes, memory request/ack, flush and error status
// Misses allocate an invalid way first, otherwise the LRU way; the victim is
// frozen at the miss. Every memory wait is bounded by TIMEOUT cycles.
module cache_ctrl_nway
  import cache_pkg::*;
#(
  parameter int WAYS    = DEF_WAYS,
  parameter int SETS    = DEF_SETS,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int WAY_W   = $clog2(WAYS),
  parameter int IDX_W   = $clog2(SETS)
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_ctrl_nway_if.master bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [WAYS-1:0] ONE_W = {{(WAYS-1){1'b0}}, 1'b1};

  cache_state_t        state;
  logic [WAY_W-1:0]    victim_q;
  logic [TMO_W-1:0]    tmo_cnt;

  logic [WAY_W-1:0]    victim_c;
  logic [MAX_WAYS-1:0] valid_pad;
  logic [IDX_W-1:0]    f_idx;
  logic [WAY_W-1:0]    f_way;
  logic                f_last;
  logic                cnt_adv;
  logic                cnt_clr;
  logic                tmo_hit;
  logic                flush_dirty;
  logic [WAYS-1:0]     hit_oh;
  logic [WAYS-1:0]     victim_oh;
  logic [WAYS-1:0]     flush_oh;

  cache_flush_cnt #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .adv   (cnt_adv),
    .idx   (f_idx),
    .way   (f_way),
    .last  (f_last)
  );

  // Victim choice: first invalid way, else the replacement unit's LRU way.
  always_comb begin
    valid_pad             = '1;
    valid_pad[WAYS-1:0]   = bus.valid_vec;
    if (&bus.valid_vec) victim_c = bus.lru_way;
    else                victim_c = WAY_W'(first_invalid(valid_pad));
  end

  // Last permitted waiting cycle: no ack here means the request has timed out.
  assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign flush_dirty = bus.dirty_vec[f_way] & bus.valid_vec[f_way];
  assign hit_oh      = ONE_W << bus.hit_way;
  assign victim_oh   = ONE_W << victim_q;
  assign flush_oh    = ONE_W << f_way;
  assign bus.state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      victim_q <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush_req)                     state <= FLUSH_SCAN;
          else if (bus.cpu_read || bus.cpu_write) state <= CHECK;
        end
        CHECK: begin
          if (bus.hit) begin
            state <= IDLE;
          end else begin
            victim_q <= victim_c;
            tmo_cnt  <= '0;
            state    <= (bus.valid_vec[victim_c] && bus.dirty_vec[victim_c]) ? WB_REQ : FILL_REQ;
          end
        end
        WB_REQ: begin
          if (bus.mem_ack) begin
            state   <= FILL_REQ;
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            state <= ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        FILL_REQ: begin
          // After the fill the set holds the line, so CHECK completes via the hit path.
          if (bus.mem_ack)   state <= CHECK;
          else if (tmo_hit)  state <= ERROR;
          else               tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        FLUSH_SCAN: begin
          if (flush_dirty) begin
            state   <= FLUSH_WB;
            tmo_cnt <= '0;
          end else if (f_last) begin
            state <= IDLE;
          end
        end
        FLUSH_WB: begin
          if (bus.mem_ack)  state <= f_last ? IDLE : FLUSH_SCAN;
          else if (tmo_hit) state <= ERROR;
          else              tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath, memory and status strobes: decoded from state and registers,
  // qualified by hit/mem_ack where a write happens in the same cycle.
  always_comb begin
    bus.cpu_ready     = 1'b0;
    bus.lru_update    = 1'b0;
    bus.lru_touch_way = '0;
    bus.byte_we       = '0;
    bus.line_we       = '0;
    bus.tag_we        = '0;
    bus.data_in_sel   = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.wb_way        = '0;
    bus.valid_we      = '0;
    bus.dirty_we      = '0;
    bus.valid_d       = 1'b0;
    bus.dirty_d       = 1'b0;
    bus.flush_active  = 1'b0;
    bus.flush_idx     = '0;
    bus.flush_done    = 1'b0;
    bus.error         = 1'b0;
    cnt_adv           = 1'b0;
    cnt_clr           = (state == IDLE);
    case (state)
      CHECK: begin
        if (bus.hit) begin
          bus.cpu_ready     = 1'b1;
          bus.lru_update    = 1'b1;
          bus.lru_touch_way = bus.hit_way;
          if (bus.cpu_write) begin
            bus.byte_we  = hit_oh;
            bus.dirty_we = hit_oh;
            bus.dirty_d  = 1'b1;
          end
        end
      end
      WB_REQ: begin
        bus.mem_write = 1'b1;
        bus.wb_way    = victim_q;
      end
      FILL_REQ: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ack) begin
          bus.line_we     = victim_oh;
          bus.tag_we      = victim_oh;
          bus.valid_we    = victim_oh;
          bus.dirty_we    = victim_oh;
          bus.data_in_sel = 1'b1;
          bus.valid_d     = 1'b1;
        end
      end
      FLUSH_SCAN: begin
        bus.flush_active = 1'b1;
        bus.flush_idx    = f_idx;
        if (!flush_dirty) begin
          cnt_adv        = 1'b1;
          bus.flush_done = f_last;
        end
      end
      FLUSH_WB: begin
        bus.flush_active = 1'b1;
        bus.flush_idx    = f_idx;
        bus.mem_write    = 1'b1;
        bus.wb_way       = f_way;
        if (bus.mem_ack) begin
          bus.dirty_we   = flush_oh;
          cnt_adv        = 1'b1;
          bus.flush_done = f_last;
        end
      end
      ERROR: bus.error = 1'b1;
      default: ;
    endcase
  end

endmodule
